// File: rtl/axil_periph_bridge_mc.sv
// AXI4-Lite slave bridge onto up to 16 simple-bus peripheral slots.
// Serves one access at a time with R/W arbitration, wait states, stall timeout and error responses.
module axil_periph_bridge_mc #(
    parameter int unsigned NUM_PERIPH = 3,
    parameter int unsigned SEL_LSB    = 8,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned PADDR_W    = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [31:0]              awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [PADDR_W-1:0]       p_addr,
    output logic [31:0]              p_wdata,
    output logic [3:0]               p_wstrb,
    output logic [NUM_PERIPH-1:0]    p_rd,
    output logic [NUM_PERIPH-1:0]    p_wr,
    input  logic [32*NUM_PERIPH-1:0] p_rdata,
    input  logic [NUM_PERIPH-1:0]    p_ready
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t                state, state_nx;
    logic                  rdy_en, aw_full, w_full, op_wr, last_wr;
    logic [31:0]           aw_addr, acc_addr, wdata_q;
    logic [3:0]            wstrb_q;
    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      slot;
    logic [NUM_PERIPH-1:0] sel;
    logic [31:0]           rdata_sel;
    logic                  ready_sel, slot_ok, timeout_hit;
    logic                  grant_rd, grant_wr, acc_done, cnt_inc;
    logic [1:0]            resp_code;
    logic                  aw_hs, w_hs, r_hs, b_hs;
    logic                  unused_ok;

    assign awready = rdy_en && !aw_full;
    assign wready  = rdy_en && !w_full;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign r_hs    = rvalid && rready;
    assign b_hs    = bvalid && bready;

    assign slot        = acc_addr[SEL_LSB +: SEL_W];
    assign p_addr      = acc_addr[PADDR_W-1:0];
    assign p_wdata     = wdata_q;
    assign p_wstrb     = wstrb_q;
    assign ready_sel   = |(p_ready & sel);
    assign slot_ok     = |sel;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
    assign unused_ok   = ^acc_addr;

    // Slot decode; only the selected slot's ready/rdata are looked at
    always_comb begin
        sel       = '0;
        rdata_sel = '0;
        for (int k = 0; k < int'(NUM_PERIPH); k++) begin
            sel[k] = (slot == SEL_W'(k));
            if (slot == SEL_W'(k)) rdata_sel = rdata_sel | p_rdata[32*k +: 32];
        end
    end

    // Awready/wready stay low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Independent AW and W buffers, both released by the B handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (b_hs) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        arready   = 1'b0;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        acc_done  = 1'b0;
        cnt_inc   = 1'b0;
        resp_code = RESP_OKAY;
        p_rd      = '0;
        p_wr      = '0;
        case (state)
            IDLE: begin
                // On a tie the direction not served last wins
                if (rdy_en && arvalid && (!(aw_full && w_full) || last_wr)) grant_rd = 1'b1;
                else if (rdy_en && aw_full && w_full)                        grant_wr = 1'b1;
                arready = grant_rd;
                if (grant_rd || grant_wr) state_nx = ACC;
            end
            ACC: begin
                if (!slot_ok) begin
                    acc_done  = 1'b1;
                    resp_code = RESP_DECERR;
                end else if (timeout_hit) begin
                    acc_done  = 1'b1;
                    resp_code = RESP_SLVERR;
                end else begin
                    if (op_wr) p_wr = sel;
                    else       p_rd = sel;
                    if (ready_sel) acc_done = 1'b1;
                    else           cnt_inc  = 1'b1;
                end
                if (acc_done) state_nx = RESP;
            end
            RESP: begin
                if (r_hs || b_hs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Access registers, wait counter and AXI response channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_addr <= '0;
            op_wr    <= 1'b0;
            last_wr  <= 1'b0;
            cnt      <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
        end else begin
            if (grant_rd) begin
                acc_addr <= araddr;
                op_wr    <= 1'b0;
                cnt      <= '0;
            end else if (grant_wr) begin
                acc_addr <= aw_addr;
                op_wr    <= 1'b1;
                cnt      <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (acc_done && !op_wr) begin
                rvalid <= 1'b1;
                rresp  <= resp_code;
                rdata  <= (resp_code == RESP_OKAY) ? rdata_sel : 32'h0;
            end
            if (acc_done && op_wr) begin
                bvalid <= 1'b1;
                bresp  <= resp_code;
            end
            if (r_hs) begin
                rvalid  <= 1'b0;
                last_wr <= 1'b0;
            end
            if (b_hs) begin
                bvalid  <= 1'b0;
                last_wr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_periph_bridge_mc.sv
// Directed bench for axil_periph_bridge_mc with default parameters (3 slots, TIMEOUT=15).
module tb_axil_periph_bridge_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb, p_wstrb;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;
    logic [2:0]  p_rd, p_wr, p_ready;
    logic [31:0] pd0, pd1, pd2;
    logic [95:0] p_rdata;

    int n_cmp = 0;
    int n_err = 0;

    assign p_rdata = {pd2, pd1, pd0};

    always #5 clk = ~clk;

    axil_periph_bridge_mc dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_wstrb(p_wstrb),
        .p_rd(p_rd), .p_wr(p_wr), .p_rdata(p_rdata), .p_ready(p_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] order;
        int          nlog, wcnt;
        logic        got, stable, seen;

        rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        p_ready = 3'b111; pd0 = 32'hAAAA_0000; pd1 = 32'h1234_5678; pd2 = 32'hCCCC_0002;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'({arready, awready, wready}), 32'h0);
        chk("rst_valid", 32'({rvalid, bvalid}), 32'h0);
        chk("rst_strobe", 32'({p_rd, p_wr}), 32'h0);
        chk("rst_data", rdata | p_wdata | 32'(p_addr) | 32'({rresp, bresp, p_wstrb}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready_wready", 32'({awready, wready}), 32'h3);

        // Zero-wait read of slot 1
        araddr = 32'h0000_0104; arvalid = 1'b1; rready = 1'b1;
        #1 chk("rd0_arready", 32'(arready), 32'h1);
        @(negedge clk); arvalid = 1'b0;
        chk("rd0_p_rd", 32'(p_rd), 32'h2);
        chk("rd0_p_addr", 32'(p_addr), 32'h04);
        @(negedge clk);
        chk("rd0_strobe_off", 32'(p_rd), 32'h0);
        chk("rd0_rvalid", 32'(rvalid), 32'h1);
        chk("rd0_rdata", rdata, 32'h1234_5678);
        chk("rd0_rresp", 32'(rresp), 32'h0);
        @(negedge clk);
        chk("rd0_rvalid_clr", 32'(rvalid), 32'h0);

        // Write with W three cycles ahead of AW
        wdata = 32'hA5A5_0F0F; wstrb = 4'b0110; wvalid = 1'b1;
        #1 chk("wr_wready", 32'(wready), 32'h1);
        @(negedge clk); wvalid = 1'b0;
        chk("wr_wready_drop", 32'(wready), 32'h0);
        repeat (2) @(negedge clk);
        awaddr = 32'h0000_0208; awvalid = 1'b1;
        #1 chk("wr_awready", 32'(awready), 32'h1);
        @(negedge clk); awvalid = 1'b0;
        chk("wr_grant_cycle", 32'({awready, p_wr}), 32'h0);
        @(negedge clk);
        chk("wr_p_wr", 32'(p_wr), 32'h4);
        chk("wr_p_addr", 32'(p_addr), 32'h08);
        chk("wr_p_wdata", p_wdata, 32'hA5A5_0F0F);
        chk("wr_p_wstrb", 32'(p_wstrb), 32'h6);
        @(negedge clk);
        chk("wr_bvalid", 32'({p_wr, bvalid}), 32'h1);
        chk("wr_bresp", 32'(bresp), 32'h0);
        bready = 1'b1;
        @(negedge clk);
        chk("wr_b_done", 32'({bvalid, awready, wready}), 32'h3);

        // Unmapped slot 5: read then write
        araddr = 32'h0000_0500; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        chk("dec_rd_nostrobe", 32'(p_rd), 32'h0);
        @(negedge clk);
        chk("dec_rvalid", 32'(rvalid), 32'h1);
        chk("dec_rresp", 32'(rresp), 32'h3);
        chk("dec_rdata", rdata, 32'h0);
        @(negedge clk);
        bready = 1'b0;
        awaddr = 32'h0000_0500; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h5555_5555;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        chk("dec_wr_idle", 32'(p_wr), 32'h0);
        @(negedge clk);
        chk("dec_wr_nostrobe", 32'(p_wr), 32'h0);
        @(negedge clk);
        chk("dec_bvalid", 32'(bvalid), 32'h1);
        chk("dec_bresp", 32'(bresp), 32'h3);
        bready = 1'b1;
        @(negedge clk);
        chk("dec_b_done", 32'(bvalid), 32'h0);

        // Slot 2 with three wait states, then rready backpressure
        rready = 1'b0; p_ready = 3'b011; pd2 = 32'hDEAD_0000;
        araddr = 32'h0000_0200; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_p_rd_wait", 32'(p_rd), 32'h4);
            @(negedge clk);
        end
        p_ready = 3'b111; pd2 = 32'hCAFE_F00D;
        chk("ws_p_rd_ready", 32'(p_rd), 32'h4);
        @(negedge clk);
        pd2 = 32'h0BAD_0BAD;
        chk("ws_strobe_off", 32'(p_rd), 32'h0);
        chk("ws_rdata", rdata, 32'hCAFE_F00D);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable &= rvalid && (rdata == 32'hCAFE_F00D) && (rresp == 2'b00);
        end
        chk("ws_stable", 32'(stable), 32'h1);
        rready = 1'b1;
        @(negedge clk);
        chk("ws_rvalid_clr", 32'(rvalid), 32'h0);

        // Stall timeout on slot 0 write, then slot 1 read
        bready = 1'b0; p_ready = 3'b110;
        awaddr = 32'h0000_0010; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h0000_00FF; wstrb = 4'hF;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        wcnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (p_wr[0]) wcnt++;
            if (bvalid) got = 1'b1;
        end
        chk("to_bvalid", 32'(got), 32'h1);
        chk("to_strobe_cycles", 32'(wcnt), 32'd15);
        chk("to_bresp", 32'(bresp), 32'h2);
        bready = 1'b1;
        @(negedge clk);
        araddr = 32'h0000_0100; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk);
        chk("to_next_rd_rvalid", 32'(rvalid), 32'h1);
        chk("to_next_rd_rdata", rdata, 32'h1234_5678);
        chk("to_next_rd_rresp", 32'(rresp), 32'h0);
        @(negedge clk);

        // AR and AW+W continuously offered: grant order alternates starting with write
        p_ready = 3'b111;
        awaddr = 32'h0; wdata = 32'h1111_2222; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        araddr = 32'h0000_0100; arvalid = 1'b1;
        order = '0; nlog = 0;
        for (int i = 0; i < 60 && nlog < 4; i++) begin
            @(negedge clk);
            if (p_wr != 3'b000) begin
                order = {order[23:0], 8'h57};
                nlog++;
            end else if (p_rd != 3'b000) begin
                order = {order[23:0], 8'h52};
                nlog++;
            end
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("arb_order", order, 32'h5752_5752);
        repeat (10) @(negedge clk);

        // Reset pulsed during a stalled read
        p_ready = 3'b101;
        araddr = 32'h0000_0100; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        chk("mrst_p_rd_before", 32'(p_rd), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_p_rd_async", 32'(p_rd), 32'h0);
        chk("mrst_valid_async", 32'({rvalid, bvalid}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; p_ready = 3'b111;
        @(negedge clk);
        chk("mrst_ready_after", 32'({awready, wready}), 32'h3);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= rvalid | bvalid | (|p_rd);
        end
        chk("mrst_no_response", 32'(seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
